pwm_generator: RTL



---
 rtl/pwm_generator.sv | 92 +++++++++
 1 files changed

// File: rtl/pwm_generator.sv
// 16-pin PWM driver with shared prescaler/counter and per-pin off/static/PWM select.
// Define PWM_SYNC_UPDATE_EN to shadow the duty cycle and apply changes only at period boundaries.
module pwm_generator #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [15:0] PRESC_LAST = 16'(CLK_DIV - 1);
  localparam logic [7:0]  CNT_LAST   = 8'd254;

  logic [15:0] presc_q, presc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] out_q, out_d;
  logic        period_start_q;
  logic        tick;
  logic        boundary;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty_eff;
  logic        pwm_level;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

`ifdef PWM_SYNC_UPDATE_EN
  logic [7:0] duty_shadow_q, duty_shadow_d;
  logic       load_pending_q, load_pending_d;

  always_comb begin
    duty_shadow_d  = duty_shadow_q;
    load_pending_d = load_pending_q;
    if (boundary || load_pending_q) begin
      duty_shadow_d  = pwm_duty_cycle;
      load_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_shadow_q  <= '0;
      load_pending_q <= 1'b1;
    end else begin
      duty_shadow_q  <= duty_shadow_d;
      load_pending_q <= load_pending_d;
    end
  end

  assign duty_eff = duty_shadow_q;
`else
  assign duty_eff = pwm_duty_cycle;
`endif

  always_comb begin
    tick     = (presc_q == PRESC_LAST);
    presc_d  = tick ? '0 : presc_q + 16'd1;
    boundary = tick && (cnt_q == CNT_LAST);
    cnt_d    = cnt_q;
    if (tick) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 8'd1;
    end
    // 0xFF must be fully on even though the counter never reaches 255
    pwm_level = (duty_eff == 8'hFF) | (cnt_q < duty_eff);
    out_d     = en_out & (~en_pwm | {16{pwm_level}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q        <= '0;
      cnt_q          <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      out_q          <= out_d;
      period_start_q <= boundary;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule
